jtag_tap_sampled: RTL

IEEE 1149.1 TAP controller that consumes the tck/tms/tdi produced by the JTAG VPI driver (or board pins) and returns tdo. The JTAG lines are oversampled in the system clock domain, so the block needs no tck clock tree. It implements the 16-state TAP FSM, a 4-bit IR, IDCODE, BYPASS and one user data register exposed to the debug logic.

---
 rtl/jtag_tap_pkg.sv | 55 +++++
 rtl/jtag_tap_sync.sv | 45 ++++
 rtl/jtag_tap_sampled.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared constants for the oversampled JTAG TAP: IEEE 1149.1 state codes,
// instruction opcodes, the IR capture pattern and the TAP next-state function.
package jtag_tap_pkg;

   // State codes follow the IEEE 1149.1 encoding so tap_state can be exported directly.
   typedef enum logic [3:0] {
      StExit2Dr        = 4'h0,
      StExit1Dr        = 4'h1,
      StShiftDr        = 4'h2,
      StPauseDr        = 4'h3,
      StSelectIr       = 4'h4,
      StUpdateDr       = 4'h5,
      StCaptureDr      = 4'h6,
      StSelectDr       = 4'h7,
      StExit2Ir        = 4'h8,
      StExit1Ir        = 4'h9,
      StShiftIr        = 4'hA,
      StPauseIr        = 4'hB,
      StRunTestIdle    = 4'hC,
      StUpdateIr       = 4'hD,
      StCaptureIr      = 4'hE,
      StTestLogicReset = 4'hF
   } tap_state_e;

   localparam logic [3:0] OPC_IDCODE = 4'h1;
   localparam logic [3:0] OPC_USER   = 4'h8;
   localparam logic [3:0] OPC_BYPASS = 4'hF;
   localparam logic [3:0] IR_CAPTURE = 4'b0101;

   function automatic tap_state_e tap_next_state(input tap_state_e s, input logic tms);
      tap_state_e n;
      n = StTestLogicReset;
      case (s)
         StTestLogicReset: n = tms ? StTestLogicReset : StRunTestIdle;
         StRunTestIdle:    n = tms ? StSelectDr       : StRunTestIdle;
         StSelectDr:       n = tms ? StSelectIr       : StCaptureDr;
         StCaptureDr:      n = tms ? StExit1Dr        : StShiftDr;
         StShiftDr:        n = tms ? StExit1Dr        : StShiftDr;
         StExit1Dr:        n = tms ? StUpdateDr       : StPauseDr;
         StPauseDr:        n = tms ? StExit2Dr        : StPauseDr;
         StExit2Dr:        n = tms ? StUpdateDr       : StShiftDr;
         StUpdateDr:       n = tms ? StSelectDr       : StRunTestIdle;
         StSelectIr:       n = tms ? StTestLogicReset : StCaptureIr;
         StCaptureIr:      n = tms ? StExit1Ir        : StShiftIr;
         StShiftIr:        n = tms ? StExit1Ir        : StShiftIr;
         StExit1Ir:        n = tms ? StUpdateIr       : StPauseIr;
         StPauseIr:        n = tms ? StExit2Ir        : StPauseIr;
         StExit2Ir:        n = tms ? StUpdateIr       : StShiftIr;
         StUpdateIr:       n = tms ? StSelectDr       : StRunTestIdle;
         default:          n = StTestLogicReset;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jtag_tap_sync.sv
// Synchronizes tck/tms/tdi into the clk domain and detects tck edges.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   tck, tms, tdi     raw JTAG inputs
//   tms_sync/tdi_sync synchronized tms/tdi, aligned with the tck edge pulses
//   tck_rise/tck_fall one-clk pulses on synchronized tck 0->1 / 1->0
module jtag_tap_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tck,
   input  logic tms,
   input  logic tdi,
   output logic tms_sync,
   output logic tdi_sync,
   output logic tck_rise,
   output logic tck_fall
);

   logic [SYNC_STAGES-1:0] tck_q, tms_q, tdi_q;
   logic                   tck_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tck_q      <= '0;
         tms_q      <= '0;
         tdi_q      <= '0;
         tck_prev_q <= 1'b0;
      end else begin
         tck_q      <= {tck_q[SYNC_STAGES-2:0], tck};
         tms_q      <= {tms_q[SYNC_STAGES-2:0], tms};
         tdi_q      <= {tdi_q[SYNC_STAGES-2:0], tdi};
         tck_prev_q <= tck_q[SYNC_STAGES-1];
      end
   end

   always_comb begin
      tms_sync = tms_q[SYNC_STAGES-1];
      tdi_sync = tdi_q[SYNC_STAGES-1];
      tck_rise = tck_q[SYNC_STAGES-1] & ~tck_prev_q;
      tck_fall = ~tck_q[SYNC_STAGES-1] & tck_prev_q;
   end

endmodule

// File: rtl/jtag_tap_sampled.sv
// IEEE 1149.1 TAP controller running entirely in the clk domain; tck is
// oversampled rather than used as a clock. Implements IR, IDCODE, BYPASS and
// one user data register.
// Ports:
//   clk, rst_n               system clock, async active-low reset
//   tck, tms, tdi, tdo       JTAG lines; tdo_oe marks tdo valid (shift states)
//   tap_state                current TAP state (IEEE code)
//   ir_out                   current instruction
//   user_dr_in/user_dr_out   USER register capture source / update result
//   user_capture/user_update one-clk pulses on USER Capture-DR / Update-DR
module jtag_tap_sampled
   import jtag_tap_pkg::*;
#(
   parameter int unsigned IR_WIDTH      = 4,
   parameter logic [31:0] IDCODE_VALUE  = 32'h149511C3,
   parameter int unsigned USER_DR_WIDTH = 32,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tck,
   input  logic                     tms,
   input  logic                     tdi,
   output logic                     tdo,
   output logic                     tdo_oe,
   output logic [3:0]               tap_state,
   output logic [IR_WIDTH-1:0]      ir_out,
   input  logic [USER_DR_WIDTH-1:0] user_dr_in,
   output logic [USER_DR_WIDTH-1:0] user_dr_out,
   output logic                     user_capture,
   output logic                     user_update
);

   // One DR shift register shared by IDCODE, USER and BYPASS.
   localparam int unsigned DR_W = (USER_DR_WIDTH > 32) ? USER_DR_WIDTH : 32;

   logic tms_s, tdi_s, tck_rise, tck_fall;

   jtag_tap_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .tck      (tck),
      .tms      (tms),
      .tdi      (tdi),
      .tms_sync (tms_s),
      .tdi_sync (tdi_s),
      .tck_rise (tck_rise),
      .tck_fall (tck_fall)
   );

   tap_state_e               state_q, state_d;
   logic [IR_WIDTH-1:0]      ir_q, ir_d, ir_sr_q, ir_sr_d;
   logic [DR_W-1:0]          dr_sr_q, dr_sr_d, dr_shifted;
   logic                     tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
   logic [USER_DR_WIDTH-1:0] user_dr_out_q, user_dr_out_d;
   logic                     user_capture_q, user_capture_d;
   logic                     user_update_q, user_update_d;
   int unsigned              dr_len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StTestLogicReset;
         ir_q           <= IR_WIDTH'(OPC_IDCODE);
         ir_sr_q        <= '0;
         dr_sr_q        <= '0;
         tdo_q          <= 1'b0;
         tdo_oe_q       <= 1'b0;
         user_dr_out_q  <= '0;
         user_capture_q <= 1'b0;
         user_update_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         ir_q           <= ir_d;
         ir_sr_q        <= ir_sr_d;
         dr_sr_q        <= dr_sr_d;
         tdo_q          <= tdo_d;
         tdo_oe_q       <= tdo_oe_d;
         user_dr_out_q  <= user_dr_out_d;
         user_capture_q <= user_capture_d;
         user_update_q  <= user_update_d;
      end
   end

   // Active DR length for the current instruction; unknown opcodes act as BYPASS.
   always_comb begin
      dr_len = 1;
      if (ir_q == IR_WIDTH'(OPC_IDCODE)) begin
         dr_len = 32;
      end else if (ir_q == IR_WIDTH'(OPC_USER)) begin
         dr_len = USER_DR_WIDTH;
      end
   end

   assign dr_shifted = {tdi_s, dr_sr_q[DR_W-1:1]};

   always_comb begin
      state_d        = state_q;
      ir_d           = ir_q;
      ir_sr_d        = ir_sr_q;
      dr_sr_d        = dr_sr_q;
      tdo_d          = tdo_q;
      tdo_oe_d       = tdo_oe_q;
      user_dr_out_d  = user_dr_out_q;
      user_capture_d = 1'b0;
      user_update_d  = 1'b0;

      if (tck_rise) begin
         state_d = tap_next_state(state_q, tms_s);
         case (state_q)
            StCaptureIr: ir_sr_d = IR_WIDTH'(IR_CAPTURE);
            StShiftIr:   ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
            StCaptureDr: begin
               if (ir_q == IR_WIDTH'(OPC_IDCODE)) begin
                  dr_sr_d = DR_W'(IDCODE_VALUE);
               end else if (ir_q == IR_WIDTH'(OPC_USER)) begin
                  dr_sr_d        = DR_W'(user_dr_in);
                  user_capture_d = 1'b1;
               end else begin
                  dr_sr_d = '0;
               end
            end
            StShiftDr: begin
               // tdi enters at bit dr_len-1; bits above the active length are left alone.
               for (int unsigned i = 0; i < DR_W; i++) begin
                  if (i + 1 < dr_len) begin
                     dr_sr_d[i] = dr_shifted[i];
                  end else if (i + 1 == dr_len) begin
                     dr_sr_d[i] = tdi_s;
                  end
               end
            end
            default: ;
         endcase
      end else if (tck_fall) begin
         if (state_q == StShiftIr) begin
            tdo_d    = ir_sr_q[0];
            tdo_oe_d = 1'b1;
         end else if (state_q == StShiftDr) begin
            tdo_d    = dr_sr_q[0];
            tdo_oe_d = 1'b1;
         end else begin
            tdo_oe_d = 1'b0;
         end
         if (state_q == StUpdateIr) begin
            ir_d = ir_sr_q;
         end
         if (state_q == StUpdateDr && ir_q == IR_WIDTH'(OPC_USER)) begin
            user_dr_out_d = dr_sr_q[USER_DR_WIDTH-1:0];
            user_update_d = 1'b1;
         end
      end

      if (state_q == StTestLogicReset) begin
         ir_d = IR_WIDTH'(OPC_IDCODE);
      end
   end

   always_comb begin
      tdo          = tdo_q;
      tdo_oe       = tdo_oe_q;
      tap_state    = state_q;
      ir_out       = ir_q;
      user_dr_out  = user_dr_out_q;
      user_capture = user_capture_q;
      user_update  = user_update_q;
   end

endmodule
